// File: rtl/timer_pkg.sv
// Shared register-map constants for the multi-channel interval timer.
package timer_pkg;

  // Word offsets of the four registers inside a channel's window
  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_off_e;

  // STATUS bit positions
  localparam int unsigned BIT_TO  = 0;
  localparam int unsigned BIT_RUN = 1;

  // CONTROL bit positions
  localparam int unsigned BIT_ITO   = 0;
  localparam int unsigned BIT_CONT  = 1;
  localparam int unsigned BIT_START = 2;
  localparam int unsigned BIT_STOP  = 3;

  // Multi-bit fields
  localparam int unsigned MISSED_LSB   = 8;
  localparam int unsigned MISSED_MSB   = 15;
  localparam int unsigned PRESCALE_LSB = 8;
  localparam int unsigned PRESCALE_MSB = 15;

  localparam logic [7:0] MISSED_MAX = 8'hFF;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, down-counter, RUN/TO/MISSED state and snapshot.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned       CNT_W        = 32,
  parameter logic [CNT_W-1:0]  RESET_PERIOD = CNT_W'(49999)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_status,
  input  logic             wr_control,
  input  logic             wr_period,
  input  logic             wr_snap,
  input  logic [31:0]      writedata,
  output logic             to_flag,
  output logic             run,
  output logic [7:0]       missed,
  output logic             ito,
  output logic             cont,
  output logic [7:0]       prescale,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic             irq_term
);

  logic [CNT_W-1:0] cnt;
  logic [7:0]       pre;
  logic             reload_pend;
  logic             start;
  logic             stop;
  logic             to_clr;
  logic             tick;
  logic             timeout;

  assign start    = wr_control & writedata[BIT_START];
  assign stop     = wr_control & writedata[BIT_STOP];
  assign to_clr   = wr_status & writedata[BIT_TO];
  assign tick     = run & (pre == prescale);
  assign timeout  = tick & (cnt == '0);
  assign irq_term = to_flag & ito;

  // Prescaler: free-runs while RUN, wraps on tick, restarts on START/STOP/PERIOD write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (start | stop | wr_period) begin
      pre <= '0;
    end else if (run) begin
      pre <= tick ? '0 : pre + 8'd1;
    end
  end

  // Down-counter; a PERIOD write forces a reload one cycle later so the new value is used
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= RESET_PERIOD;
      reload_pend <= 1'b0;
    end else begin
      reload_pend <= wr_period;
      if (reload_pend) begin
        cnt <= period;
      end else if (tick) begin
        cnt <= timeout ? period : cnt - CNT_W'(1);
      end
    end
  end

  // RUN: later assignments take priority (STOP/PERIOD over START over one-shot expiry)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
    end else begin
      if (timeout && !cont) run <= 1'b0;
      if (start)            run <= 1'b1;
      if (stop | wr_period) run <= 1'b0;
    end
  end

  // TO / MISSED: a timeout in the same cycle as a clear keeps TO set but still zeroes MISSED
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_flag <= 1'b0;
      missed  <= '0;
    end else if (timeout) begin
      if (to_clr) begin
        to_flag <= 1'b1;
        missed  <= '0;
      end else if (!to_flag) begin
        to_flag <= 1'b1;
      end else if (missed != MISSED_MAX) begin
        missed <= missed + 8'd1;
      end
    end else if (to_clr) begin
      to_flag <= 1'b0;
      missed  <= '0;
    end
  end

  // Software-visible CONTROL, PERIOD and snapshot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ito      <= 1'b0;
      cont     <= 1'b0;
      prescale <= '0;
      period   <= RESET_PERIOD;
      snap     <= '0;
    end else begin
      if (wr_control) begin
        ito      <= writedata[BIT_ITO];
        cont     <= writedata[BIT_CONT];
        prescale <= writedata[PRESCALE_MSB:PRESCALE_LSB];
      end
      if (wr_period) period <= writedata[CNT_W-1:0];
      if (wr_snap)   snap   <= cnt;
    end
  end

endmodule

// File: rtl/avalon_multi_timer.sv
// Avalon-MM multi-channel interval timer: address decode, read mux and irq combine.
module avalon_multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 49999,
  localparam int unsigned ADDR_W      = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  logic              wr_en;
  logic [ADDR_W-1:0] ch_sel;
  reg_off_e          off;
  logic [31:0]       rd_mux;

  logic              to_flag  [NUM_CH];
  logic              run      [NUM_CH];
  logic [7:0]        missed   [NUM_CH];
  logic              ito      [NUM_CH];
  logic              cont     [NUM_CH];
  logic [7:0]        prescale [NUM_CH];
  logic [CNT_W-1:0]  period   [NUM_CH];
  logic [CNT_W-1:0]  snap     [NUM_CH];
  logic [NUM_CH-1:0] irq_terms;

  assign wr_en  = chipselect & ~write_n;
  assign ch_sel = address >> 2;
  assign off    = reg_off_e'(address[1:0]);
  assign irq    = |irq_terms;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit;
    assign hit = wr_en & (ch_sel == ADDR_W'(c));

    timer_channel #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (CNT_W'(RESET_PERIOD))
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .wr_status  (hit & (off == REG_STATUS)),
      .wr_control (hit & (off == REG_CONTROL)),
      .wr_period  (hit & (off == REG_PERIOD)),
      .wr_snap    (hit & (off == REG_SNAP)),
      .writedata  (writedata),
      .to_flag    (to_flag[c]),
      .run        (run[c]),
      .missed     (missed[c]),
      .ito        (ito[c]),
      .cont       (cont[c]),
      .prescale   (prescale[c]),
      .period     (period[c]),
      .snap       (snap[c]),
      .irq_term   (irq_terms[c])
    );
  end

  // Read mux: unmapped channels and unimplemented bits read 0
  always_comb begin
    rd_mux = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_sel == ADDR_W'(c)) begin
        case (off)
          REG_STATUS: begin
            rd_mux[BIT_TO]                = to_flag[c];
            rd_mux[BIT_RUN]               = run[c];
            rd_mux[MISSED_MSB:MISSED_LSB] = missed[c];
          end
          REG_CONTROL: begin
            rd_mux[BIT_ITO]                   = ito[c];
            rd_mux[BIT_CONT]                  = cont[c];
            rd_mux[PRESCALE_MSB:PRESCALE_LSB] = prescale[c];
          end
          REG_PERIOD: rd_mux[CNT_W-1:0] = period[c];
          REG_SNAP:   rd_mux[CNT_W-1:0] = snap[c];
          default:    rd_mux = '0;
        endcase
      end
    end
  end

  // Registered read data, one cycle latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Self-checking bench for avalon_multi_timer (3 channels, so channel index 3 is unmapped).
module tb_avalon_multi_timer;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned ADDR_W = $clog2(NUM_CH) + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  string       name_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_multi_timer #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .RESET_PERIOD (49999)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Queue the expected value, perform the read, and queue what the DUT returned
  task automatic sb_read(input logic [ADDR_W-1:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    obs_q.push_back(readdata);
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e, o; string nm;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: irq=%b expected 0", irq); end
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: readdata=0x%08h expected 0x0", readdata); end
    sb_read(2,  32'd49999, "rst_period0");
    sb_read(0,  32'h0,     "rst_status0");
    sb_read(1,  32'h0,     "rst_control0");
    sb_read(3,  32'h0,     "rst_snap0");
    sb_read(10, 32'd49999, "rst_period2");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: readdata=0x%08h expected 0x%08h", nm, o, e); end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] e, o; string nm;
    bus_write(12, 32'hFFFF_FFFF);
    bus_write(13, 32'h0000_FFFF);
    bus_write(14, 32'd5);
    sb_read(12, 32'h0,     "unmapped_status");
    sb_read(13, 32'h0,     "unmapped_control");
    sb_read(14, 32'h0,     "unmapped_period");
    sb_read(5,  32'h0,     "no_alias_control1");
    sb_read(2,  32'd49999, "no_alias_period0");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: readdata=0x%08h expected 0x%08h", nm, o, e); end
    end
  endtask

  task automatic test_continuous();
    logic [31:0] e, o; string nm; int k;
    bus_write(2, 32'd5);
    bus_write(1, 32'h7);
    k = 0;
    while (!irq && k < 50) begin @(posedge clk); #1; k++; end
    n_checks++;
    if (k !== 6) begin n_fail++; $display("FAIL cont_first_to: cycles=%0d expected 6", k); end
    bus_write(0, 32'h1);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL cont_irq_clear: irq=%b expected 0", irq); end
    k = 0;
    while (!irq && k < 50) begin @(posedge clk); #1; k++; end
    n_checks++;
    if (k !== 5) begin n_fail++; $display("FAIL cont_second_to: cycles=%0d expected 5", k); end
    bus_write(1, 32'h8);
    bus_write(0, 32'h1);
    bus_write(3, 32'h0);
    sb_read(0, 32'h0, "cont_status_stopped");
    sb_read(3, 32'd4, "cont_snap_held");
    sb_read(1, 32'h0, "cont_control_strobes");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: readdata=0x%08h expected 0x%08h", nm, o, e); end
    end
  endtask

  task automatic test_oneshot_prescale();
    logic [31:0] e, o; string nm; int k;
    bus_write(6, 32'd3);
    bus_write(5, 32'h0305);
    k = 0;
    while (!irq && k < 100) begin @(posedge clk); #1; k++; end
    n_checks++;
    if (k !== 16) begin n_fail++; $display("FAIL os_to_latency: cycles=%0d expected 16", k); end
    bus_write(7, 32'h0);
    sb_read(4, 32'h1,    "os_status");
    sb_read(7, 32'd3,    "os_snap_reloaded");
    sb_read(5, 32'h0301, "os_control");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: readdata=0x%08h expected 0x%08h", nm, o, e); end
    end
    bus_write(4, 32'h1);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL os_irq_clear: irq=%b expected 0", irq); end
  endtask

  task automatic test_missed();
    logic [31:0] e, o; string nm; int unsigned t0;
    bus_write(2, 32'd2);
    bus_write(1, 32'h6);
    repeat (30) @(posedge clk);
    #1;
    bus_write(1, 32'hA);
    sb_read(0, 32'h0901, "missed_nine");
    // Restart from cnt=1: timeouts land on edges t0+2+3j
    bus_write(1, 32'h6);
    t0 = cyc;
    repeat (900) @(posedge clk);
    #1;
    sb_read(0, 32'hFF03, "missed_saturated");
    while (((cyc + 1 - t0 - 2) % 3) == 0) begin @(posedge clk); #1; end
    bus_write(0, 32'h1);
    sb_read(0, 32'h2, "clear_status");
    while (((cyc + 1 - t0 - 2) % 3) != 0) begin @(posedge clk); #1; end
    bus_write(0, 32'h1);
    sb_read(0, 32'h3, "clear_vs_timeout");
    bus_write(1, 32'hE);
    sb_read(0, 32'h1, "start_stop_status");
    sb_read(1, 32'h2, "start_stop_control");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: readdata=0x%08h expected 0x%08h", nm, o, e); end
    end
    bus_write(0, 32'h1);
  endtask

  task automatic test_reset_midcount();
    logic [31:0] e, o; string nm;
    bus_write(10, 32'd0);
    bus_write(9,  32'h5);
    bus_write(2,  32'd2000);
    bus_write(1,  32'h5);
    repeat (999) @(posedge clk);
    #1;
    bus_write(3, 32'h0);
    sb_read(3, 32'd1001, "mid_snap");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: readdata=0x%08h expected 0x%08h", nm, o, e); end
    end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: irq=%b expected 1", irq); end
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL async_readdata: readdata=0x%08h expected 0x0", readdata); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL async_irq: irq=%b expected 0", irq); end
    @(posedge clk); #1;
    reset = 1'b0;
    sb_read(2, 32'd49999, "post_period0");
    sb_read(0, 32'h0,     "post_status0");
    sb_read(1, 32'h0,     "post_control0");
    sb_read(3, 32'h0,     "post_snap0");
    sb_read(8, 32'h0,     "post_status2");
    sb_read(9, 32'h0,     "post_control2");
    bus_write(3, 32'h0);
    sb_read(3, 32'd49999, "post_cnt0");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: readdata=0x%08h expected 0x%08h", nm, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_unmapped();
    test_continuous();
    test_oneshot_prescale();
    test_missed();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
